// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared state type and frame constants for the frame serializer
package frame_pkg;
    localparam int DEF_CODE_WIDTH = 10;
    localparam int DEF_WORD_WIDTH = 32;
    localparam int DATA_LEN       = DEF_CODE_WIDTH + DEF_WORD_WIDTH;
    localparam int FRAME_LEN      = DATA_LEN + 2;
    localparam logic START_BIT    = 1'b1;

    typedef enum logic [1:0] {IDLE, START, DATA, PARITY} state_t;
endpackage

// File: rtl/frame_pending_slot.sv
// rtl/frame_pending_slot.sv - one-entry holding register for a transfer waiting behind the active frame
module frame_pending_slot #(
    parameter int CODE_WIDTH = 10,
    parameter int WORD_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  take,
    input  logic [CODE_WIDTH-1:0] load_code,
    input  logic [WORD_WIDTH-1:0] load_word,
    output logic                  full,
    output logic [CODE_WIDTH-1:0] code,
    output logic [WORD_WIDTH-1:0] word
);
    always_ff @(posedge clk) begin
        if (reset) begin
            full <= 1'b0;
            code <= '0;
            word <= '0;
        end else begin
            if (load) begin
                full <= 1'b1;
                code <= load_code;
                word <= load_word;
            end else if (take) begin
                full <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/frame_serializer.sv
// rtl/frame_serializer.sv - frames code+word transfers into an MSB-first serial stream with even parity
module frame_serializer
    import frame_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int CODE_WIDTH = DEF_CODE_WIDTH
) (
    input  logic                  sysclk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CODE_WIDTH-1:0] in_code,
    input  logic [WORD_WIDTH-1:0] in_word,
    output logic                  ser_out,
    output logic                  ser_frame,
    output logic                  ser_start,
    output logic                  ser_done,
    output logic                  busy
);
    localparam int DLEN = CODE_WIDTH + WORD_WIDTH;
    localparam int CW   = $clog2(DLEN);

    state_t              state, state_nx;
    logic [DLEN-1:0]     shift_q, shift_nx;
    logic [CW-1:0]       cnt_q, cnt_nx;
    logic                parity_q, parity_nx;
    logic                ser_out_nx;
    logic                accept, pend_load, pend_take, pend_full;
    logic [CODE_WIDTH-1:0] pend_code;
    logic [WORD_WIDTH-1:0] pend_word;

    assign in_ready = !pend_full && !reset;
    assign accept   = in_valid && in_ready;
    assign busy     = !reset && ((state != IDLE) || pend_full);

    frame_pending_slot #(.CODE_WIDTH(CODE_WIDTH), .WORD_WIDTH(WORD_WIDTH)) u_pending (
        .clk       (sysclk),
        .reset     (reset),
        .load      (pend_load),
        .take      (pend_take),
        .load_code (in_code),
        .load_word (in_word),
        .full      (pend_full),
        .code      (pend_code),
        .word      (pend_word)
    );

    // Outputs are registered, so the next-cycle bit is chosen here from the next state.
    always_comb begin
        state_nx   = state;
        shift_nx   = shift_q;
        cnt_nx     = cnt_q;
        parity_nx  = parity_q;
        ser_out_nx = 1'b0;
        pend_load  = 1'b0;
        pend_take  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nx   = START;
                    shift_nx   = {in_code, in_word};
                    ser_out_nx = START_BIT;
                end
            end
            START: begin
                pend_load  = accept;
                state_nx   = DATA;
                cnt_nx     = '0;
                ser_out_nx = shift_q[DLEN-1];
                parity_nx  = shift_q[DLEN-1];
                shift_nx   = shift_q << 1;
            end
            DATA: begin
                pend_load = accept;
                if (cnt_q == CW'(DLEN - 1)) begin
                    state_nx   = PARITY;
                    ser_out_nx = parity_q;
                end else begin
                    cnt_nx     = cnt_q + 1'b1;
                    ser_out_nx = shift_q[DLEN-1];
                    parity_nx  = parity_q ^ shift_q[DLEN-1];
                    shift_nx   = shift_q << 1;
                end
            end
            PARITY: begin
                // Pending transfer wins; otherwise a fresh accept bypasses the slot.
                if (pend_full) begin
                    pend_take  = 1'b1;
                    state_nx   = START;
                    shift_nx   = {pend_code, pend_word};
                    ser_out_nx = START_BIT;
                end else if (accept) begin
                    state_nx   = START;
                    shift_nx   = {in_code, in_word};
                    ser_out_nx = START_BIT;
                end else begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            state     <= IDLE;
            shift_q   <= '0;
            cnt_q     <= '0;
            parity_q  <= 1'b0;
            ser_out   <= 1'b0;
            ser_frame <= 1'b0;
            ser_start <= 1'b0;
            ser_done  <= 1'b0;
        end else begin
            state     <= state_nx;
            shift_q   <= shift_nx;
            cnt_q     <= cnt_nx;
            parity_q  <= parity_nx;
            ser_out   <= ser_out_nx;
            ser_frame <= (state_nx != IDLE);
            ser_start <= (state_nx == START);
            ser_done  <= (state == PARITY);
        end
    end
endmodule

// File: doc/frame_serializer.md
Name: frame_serializer

Overview:
- Downstream stage of the code/complex-word generator.
- Accepts one 10-bit code plus one packed 32-bit complex word per transfer on a valid/ready handshake.
- Emits them as a framed, MSB-first serial bitstream with even parity.
- Holds one pending transfer while shifting, so frames run back-to-back with no idle gap.

Parameters:
- WORD_WIDTH, 32, width of the packed complex word.
- CODE_WIDTH, 10, width of the code field.

Ports:
- sysclk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream offers a transfer.
- in_ready  out  1  block can take a transfer this cycle.
- in_code  in  CODE_WIDTH  code field; sampled on accept.
- in_word  in  WORD_WIDTH  complex word; sampled on accept.
- ser_out  out  1  serial data bit.
- ser_frame  out  1  high for every bit of a frame (start through parity).
- ser_start  out  1  high only during the start-bit cycle.
- ser_done  out  1  one-cycle pulse in the cycle after the parity bit.
- busy  out  1  high while a frame is shifting or a transfer is pending.

Behaviour:
- Reset (sync, active-high): state=IDLE; pending slot empty; bit counter=0; shift register=0.
  - All outputs low while reset is high, including in_ready.
  - The cycle after reset deasserts, in_ready=1.
  - Reset mid-frame aborts the frame and drops any pending transfer. No ser_done is produced for it.
- Accept:
  - Accept happens when in_valid && in_ready at a rising edge.
  - in_ready = !pending_full && !reset.
  - in_valid may be held high indefinitely; each accepting edge consumes exactly one transfer.
- Frame format: FRAME_LEN = 1 + CODE_WIDTH + WORD_WIDTH + 1 bits (44 at defaults).
  - start bit = 1
  - then in_code MSB-first
  - then in_word MSB-first
  - then parity = XOR of all CODE_WIDTH+WORD_WIDTH data bits (even parity over data)
- State machine: IDLE, START, DATA, PARITY.
  - IDLE: on accept, load the shift register and go to START. Latency: accept at edge N puts the start bit on ser_out in cycle N+1.
  - START: one cycle, ser_out=1, ser_start=1. Then go to DATA with counter=0.
  - DATA: CODE_WIDTH+WORD_WIDTH cycles, shift left one bit per cycle; ser_out = current MSB of {code, word}.
    - Parity accumulates as bits leave the shift register.
    - Leave DATA when the counter reaches CODE_WIDTH+WORD_WIDTH-1.
  - PARITY: one cycle, ser_out = parity. Next state:
    - if the pending slot is full: move pending into the shift register and go to START (no gap);
    - else if an accept happens this cycle: load directly and go to START;
    - else go to IDLE.
- ser_done pulses for exactly one cycle in the cycle after PARITY. This coincides with the next START when frames are back-to-back.
- Pending slot, depth 1:
  - An accept while state != IDLE, and not already bypassed as above, fills pending.
  - With pending full, in_ready=0.
  - Pending empties on the PARITY→START transfer. in_ready returns to 1 in that following START cycle.
- Registered outputs: ser_out, ser_frame, ser_start and ser_done are registered.
- Idle levels: ser_out=0 and ser_frame=0 while IDLE.
- busy = (state != IDLE) || pending_full.
- Bit counter: 6 bits at defaults, width $clog2(CODE_WIDTH+WORD_WIDTH). It never wraps inside a frame.

Decomposition:
- Shared package frame_pkg:
  - state enum {IDLE, START, DATA, PARITY};
  - localparams DATA_LEN = CODE_WIDTH+WORD_WIDTH and FRAME_LEN = DATA_LEN+2;
  - START_BIT = 1'b1.
- One natural sub-module: frame_pending_slot, the one-entry holding register with full flag and load/take strobes.
- FSM, shifter and parity stay in frame_serializer.

Test Plan:
- Reset, then single transfer in_code=10'h3A5, in_word=32'hDEADBEEF accepted at edge N:
  - start bit in cycle N+1;
  - the next 42 bits equal 0x3A5 then 0xDEADBEEF, MSB-first;
  - parity bit 0 in cycle N+44; ser_done high in cycle N+45 only; busy low by N+45.
- Transfer code=0, word=32'h00000001:
  - last data bit 1; parity bit 1; ser_frame high for exactly 44 cycles.
- Back-to-back: in_valid held high with three transfers A, B, C:
  - in_ready drops after B is pending;
  - A, B and C frames run contiguously, each start bit directly after the previous parity, with ser_done coinciding with each following start;
  - C is accepted in the START cycle of B.
- Bypass: single frame; new in_valid asserted exactly in the PARITY cycle with pending empty:
  - the new start bit appears in the very next cycle, with no IDLE cycle.
- Reset mid-frame: assert reset during data bit 20 with a transfer pending:
  - next cycle all outputs are 0 and no ser_done appears;
  - after release, in_ready=1 and a new transfer frames correctly.
- Backpressure hold: pending full, in_valid held high with changing in_word:
  - the value sampled is the one present at the edge where in_ready returns to 1.
